// File: rtl/alu_mc_if.sv
// Handshake and data bundle between operand select, alu_mc and writeback.
interface alu_mc_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] readData1;
  logic [WIDTH-1:0] saidaMusReg;
  logic [3:0]       aluControlOut;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] aluResult;
  logic             zero;
  logic             overflow;
  logic             illegal;

  modport slave (
    input  in_valid, readData1, saidaMusReg, aluControlOut, out_ready,
    output in_ready, out_valid, aluResult, zero, overflow, illegal
  );

  modport master (
    output in_valid, readData1, saidaMusReg, aluControlOut, out_ready,
    input  in_ready, out_valid, aluResult, zero, overflow, illegal
  );
endinterface

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake and a registered result/flag stage.
// Define ALU_MUL_EN to build the iterative shift-add multiplier (op 1000).
module alu_mc #(
  parameter int unsigned WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst,
  alu_mc_if.slave  bus
);
  localparam int unsigned SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SRL = 4'b0100;
  localparam logic [3:0] OP_SRA = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_op;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_diff;
  logic             w_slt;
  logic [WIDTH-1:0] w_res;
  logic             w_ovf;
  logic             w_ill;

  logic             w_idle;
  logic             w_is_mul;
  logic             w_accept;
  logic             w_drain;
  logic             w_done_1c;
  logic             w_done_mul;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_ovf;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_ovf;
  logic             r_ill;

  assign w_a    = bus.readData1;
  assign w_b    = bus.saidaMusReg;
  assign w_op   = bus.aluControlOut;
  assign w_sh   = w_b[SHW-1:0];
  assign w_sum  = w_a + w_b;
  assign w_diff = w_a - w_b;
  assign w_slt  = $signed(w_a) < $signed(w_b);

  assign bus.in_ready = w_idle & (~r_out_valid | bus.out_ready);
  assign w_accept     = bus.in_valid & bus.in_ready;
  assign w_drain      = r_out_valid & bus.out_ready;
  assign w_done_1c    = w_accept & ~w_is_mul;

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]         r_state;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_mcand;
  // Upper half accumulates partial sums; lower half holds the unconsumed multiplier bits.
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     w_psum;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_is_mul    = (w_op == OP_MUL);
  assign w_idle      = (r_state == ST_IDLE);
  assign w_psum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_next = {w_psum, r_prod[WIDTH-1:1]};
  assign w_done_mul  = (r_state == ST_BUSY) && (r_cnt == SHW'(WIDTH - 1));
  assign w_mul_res   = w_prod_next[WIDTH-1:0];
  assign w_mul_ovf   = |w_prod_next[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && w_is_mul) begin
            r_state <= ST_BUSY;
            r_cnt   <= '0;
            r_mcand <= w_a;
            r_prod  <= {{WIDTH{1'b0}}, w_b};
          end
        end
        default: begin
          r_prod <= w_prod_next;
          if (w_done_mul) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + SHW'(1);
          end
        end
      endcase
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_idle     = 1'b1;
  assign w_done_mul = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_ovf  = 1'b0;
`endif

  always_comb begin
    w_res = '0;
    w_ovf = 1'b0;
    w_ill = 1'b0;
    case (w_op)
      OP_AND: w_res = w_a & w_b;
      OP_OR:  w_res = w_a | w_b;
      OP_NOR: w_res = ~(w_a | w_b);
      OP_ADD: begin
        w_res = w_sum;
        w_ovf = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_diff;
        w_ovf = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, w_slt};
      OP_SLL: w_res = w_a << w_sh;
      OP_SRL: w_res = w_a >> w_sh;
      OP_SRA: w_res = $unsigned($signed(w_a) >>> w_sh);
`ifdef ALU_MUL_EN
      OP_MUL: w_res = '0;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b1;
      r_ovf       <= 1'b0;
      r_ill       <= 1'b0;
    end else if (w_done_1c) begin
      r_out_valid <= 1'b1;
      r_result    <= w_res;
      r_zero      <= (w_res == '0);
      r_ovf       <= w_ovf;
      r_ill       <= w_ill;
    end else if (w_done_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_mul_res;
      r_zero      <= (w_mul_res == '0);
      r_ovf       <= w_mul_ovf;
      r_ill       <= 1'b0;
    end else if (w_drain) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.aluResult = r_result;
  assign bus.zero      = r_zero;
  assign bus.overflow  = r_ovf;
  assign bus.illegal   = r_ill;
endmodule
